systolic_result_deskew: RTL and testbench

//  Output-side collector for the 4x4 weight-stationary TPU array.
//  The array emits bottom-row normalised results (pe30..pe33_norm_out) time-skewed:

---
 rtl/systolic_result_deskew_if.sv | 28 ++
 rtl/systolic_result_deskew.sv | 189 ++++++++++++++++++
 tb/tb_systolic_result_deskew.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/systolic_result_deskew_if.sv
// rtl/systolic_result_deskew_if.sv - batch control, skewed column input and de-skewed word stream
interface systolic_result_deskew_if #(
    parameter int DEPTH = 4,
    parameter int PIX_W = 8,
    parameter int ROW_W = 8
);
    logic                   start;
    logic [ROW_W-1:0]       num_rows;
    logic [DEPTH*PIX_W-1:0] col_in;
    logic [DEPTH*PIX_W-1:0] out_data;
    logic                   out_valid;
    logic                   out_ready;
    logic                   busy;
    logic                   done;
    logic                   overflow;

    // Collector side: consumes the skewed columns, produces the word stream
    modport slave (
        input  start, num_rows, col_in, out_ready,
        output out_data, out_valid, busy, done, overflow
    );

    // Array / write-back side: issues batches, accepts words
    modport master (
        output start, num_rows, col_in, out_ready,
        input  out_data, out_valid, busy, done, overflow
    );
endinterface

// File: rtl/systolic_result_deskew.sv
// rtl/systolic_result_deskew.sv - de-skews bottom-row array results into row words and buffers them in a FWFT FIFO
module systolic_result_deskew #(
    parameter int DEPTH      = 4,
    parameter int PIX_W      = 8,
    parameter int LAT        = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int ROW_W      = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    systolic_result_deskew_if.slave bus
);
    localparam int WORD_W = DEPTH * PIX_W;
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int K_W    = ROW_W + 2;
    localparam int WC_W   = $clog2(LAT + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_CAPTURE = 2'd2,
        S_DRAIN   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [ROW_W-1:0] rows_q, rows_d;
    logic [WC_W-1:0]  wait_q, wait_d;
    logic [K_W-1:0]   k_q, k_d;
    logic             done_q, done_d;
    logic             ovf_q, ovf_d;
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WORD_W-1:0] mem_q [FIFO_DEPTH];
    logic [WORD_W-1:0] mem_d [FIFO_DEPTH];

    logic              cap_active;
    logic [K_W-1:0]    k_now;
    logic [K_W-1:0]    rows_ext;
    logic [WORD_W-1:0] aligned;
    logic              push_req;
    logic              push_ok;
    logic              pop;
    logic              fifo_empty;
    logic              fifo_full;

    // k counts edges since column 0 of row 0 was sampled; edge k=0 is the last WAIT edge
    assign cap_active = ((state_q == S_WAIT) && (wait_q == '0)) || (state_q == S_CAPTURE);
    assign k_now      = (state_q == S_CAPTURE) ? k_q : '0;
    assign rows_ext   = {2'b00, rows_q};

    // Column j is sampled only while it carries a real row, otherwise zero is loaded so
    // garbage or X on col_in never enters the delay lines.  Column j then waits DEPTH-1-j
    // more stages so every column of a row lands in the last stage on the same edge.
    for (genvar j = 0; j < DEPTH; j++) begin : g_col
        localparam int NST = DEPTH - j;
        logic [PIX_W-1:0] dly_q [NST];
        logic [PIX_W-1:0] dly_d [NST];
        logic             col_en;

        assign col_en = cap_active && (k_now >= K_W'(j)) && ((k_now - K_W'(j)) < rows_ext);

        // Sample stage plus shift of the per-column alignment line
        always_comb begin
            dly_d[0] = col_en ? bus.col_in[j*PIX_W +: PIX_W] : '0;
            for (int s = 1; s < NST; s++) begin
                dly_d[s] = dly_q[s-1];
            end
        end

        // Alignment line registers
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int s = 0; s < NST; s++) begin
                    dly_q[s] <= '0;
                end
            end else begin
                dly_q <= dly_d;
            end
        end

        assign aligned[j*PIX_W +: PIX_W] = dly_q[NST-1];
    end

    // Row k-DEPTH sits fully aligned during capture edges k >= DEPTH
    assign push_req   = (state_q == S_CAPTURE) && (k_q >= K_W'(DEPTH));
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop        = !fifo_empty && bus.out_ready;
    // A simultaneous pop frees the slot, so a push into a full FIFO still lands
    assign push_ok    = push_req && (!fifo_full || pop);

    // FIFO pointer, storage and overflow update
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        ovf_d    = ovf_q;
        if (push_ok) begin
            mem_d[wr_ptr_q[AW-1:0]] = aligned;
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push_req && !push_ok) begin
            ovf_d = 1'b1;
        end
    end

    // Batch sequencing: wait out the array latency, capture, then drain the FIFO
    always_comb begin
        state_d = state_q;
        rows_d  = rows_q;
        wait_d  = wait_q;
        k_d     = k_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    rows_d = bus.num_rows;
                    k_d    = '0;
                    if (bus.num_rows == '0) begin
                        state_d = S_DRAIN;
                    end else begin
                        state_d = S_WAIT;
                        wait_d  = WC_W'(LAT - 1);
                    end
                end
            end
            S_WAIT: begin
                if (wait_q == '0) begin
                    state_d = S_CAPTURE;
                    k_d     = K_W'(1);
                end else begin
                    wait_d = wait_q - 1'b1;
                end
            end
            S_CAPTURE: begin
                if (k_q == rows_ext + K_W'(DEPTH - 1)) begin
                    state_d = S_DRAIN;
                end else begin
                    k_d = k_q + K_W'(1);
                end
            end
            S_DRAIN: begin
                if (fifo_empty) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control and FIFO state registers; reset aborts the batch and discards the FIFO
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            rows_q   <= '0;
            wait_q   <= '0;
            k_q      <= '0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            rows_q   <= rows_d;
            wait_q   <= wait_d;
            k_q      <= k_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

    assign bus.out_valid = !fifo_empty;
    assign bus.out_data  = fifo_empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = done_q;
    assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_systolic_result_deskew.sv
// tb/tb_systolic_result_deskew.sv - directed self-checking bench for systolic_result_deskew
module tb_systolic_result_deskew;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    systolic_result_deskew_if #(.DEPTH(4), .PIX_W(8), .ROW_W(8)) bus ();

    systolic_result_deskew #(
        .DEPTH(4), .PIX_W(8), .LAT(4), .FIFO_DEPTH(8), .ROW_W(8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] got[$];
    int first_valid_e;
    int done_e;
    int done_cnt;
    int busy_cyc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input int r);
        logic [31:0] w;
        for (int j = 0; j < 4; j++) begin
            w[j*8 +: 8] = 8'(16 * r + j);
        end
        return w;
    endfunction

    task automatic drive_cols(input int e, input int n, input bit use_x);
        for (int j = 0; j < 4; j++) begin
            int r;
            r = e - 4 - j;
            if (r >= 0 && r < n)
                bus.col_in[j*8 +: 8] = 8'(16 * r + j);
            else if (use_x)
                bus.col_in[j*8 +: 8] = 8'hxx;
            else
                bus.col_in[j*8 +: 8] = 8'hEE;
        end
    endtask

    task automatic idle(input int cycles);
        bus.start = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            drive_cols(-100, 0, 1'b0);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_batch(input int n, input int ready_from, input bit use_x,
                             input int restart_at, input int rst_at, input int max_e);
        got.delete();
        first_valid_e = -1;
        done_e        = -1;
        done_cnt      = 0;
        busy_cyc      = 0;
        bus.start     = 1'b1;
        bus.num_rows  = 8'(n);
        bus.out_ready = (ready_from <= 0);
        drive_cols(0, n, use_x);
        for (int e = 0; e <= max_e; e++) begin
            @(posedge clk);
            #1;
            bus.start    = (e + 1 == restart_at);
            bus.num_rows = (e + 1 == restart_at) ? 8'd7 : 8'(n);
            rst          = (e + 1 == rst_at);
            drive_cols(e + 1, n, use_x);
            if (e == rst_at) begin
                chk("rst_mid_valid", bus.out_valid, 0);
                chk("rst_mid_busy", bus.busy, 0);
                chk("rst_mid_ovf", bus.overflow, 0);
                chk("rst_mid_done", bus.done, 0);
                chk("rst_mid_data", bus.out_data, 0);
                return;
            end
            if (bus.busy) busy_cyc++;
            if (bus.out_valid && first_valid_e < 0) first_valid_e = e;
            if (bus.out_valid) chk("x_free", $isunknown(bus.out_data), 0);
            if (bus.done) begin
                done_cnt++;
                if (done_e < 0) done_e = e;
            end
            bus.out_ready = (e + 1 >= ready_from);
            if (bus.out_valid && !bus.out_ready)
                chk("stall_hold", bus.out_data, exp_word(got.size()));
            if (bus.out_valid && bus.out_ready) got.push_back(bus.out_data);
            if (done_e >= 0 && e >= done_e + 2) break;
        end
        if (done_e < 0 && rst_at < 0) chk("timeout", 1, 0);
        bus.start = 1'b0;
    endtask

    task automatic check_words(input string tag, input int cnt);
        chk({tag, "_count"}, got.size(), cnt);
        for (int i = 0; i < cnt; i++) begin
            if (i < got.size()) chk({tag, "_word"}, got[i], exp_word(i));
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.num_rows  = '0;
        bus.out_ready = 1'b0;
        bus.col_in    = 32'hEEEEEEEE;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_data", bus.out_data, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_ovf", bus.overflow, 0);
        rst = 1'b0;
        idle(2);

        run_batch(4, 0, 1'b0, -1, -1, 60);
        check_words("t1", 4);
        chk("t1_first_valid", first_valid_e, 8);
        chk("t1_done_edge", done_e, 13);
        chk("t1_done_once", done_cnt, 1);
        chk("t1_ovf", bus.overflow, 0);
        idle(2);

        run_batch(4, 20, 1'b0, -1, -1, 60);
        check_words("t2", 4);
        chk("t2_first_valid", first_valid_e, 8);
        chk("t2_done_edge", done_e, 24);
        chk("t2_done_once", done_cnt, 1);
        idle(2);

        run_batch(10, 30, 1'b0, -1, -1, 80);
        check_words("t3", 8);
        chk("t3_done_edge", done_e, 38);
        chk("t3_ovf", bus.overflow, 1);
        idle(2);

        run_batch(0, 0, 1'b0, -1, -1, 20);
        chk("t4_done_edge", done_e, 1);
        chk("t4_no_valid", first_valid_e, -1);
        chk("t4_busy_cycles", busy_cyc, 1);
        chk("t4_done_once", done_cnt, 1);
        idle(2);

        run_batch(4, 0, 1'b1, 6, -1, 60);
        check_words("t5", 4);
        chk("t5_done_edge", done_e, 13);
        chk("t5_done_once", done_cnt, 1);
        idle(2);

        run_batch(4, 0, 1'b0, -1, 9, 60);
        rst = 1'b0;
        idle(1);
        chk("t6_empty", bus.out_valid, 0);
        run_batch(4, 0, 1'b0, -1, -1, 60);
        check_words("t6", 4);
        chk("t6_first_valid", first_valid_e, 8);
        chk("t6_done_edge", done_e, 13);
        chk("t6_ovf", bus.overflow, 0);
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
